// File: rtl/cell_test_pkg.sv
// Shared types and constants for the 4-input cell truth-table checker.
// Also holds the saturating error-counter helper used by the checker core.
package cell_test_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int VEC_W          = 4;
   localparam int NUM_VEC        = 16;
   localparam int SETTLE_DEFAULT = 4;
   localparam int CNT_W          = 4;
   localparam int ERR_W          = 5;

   localparam logic [ERR_W-1:0] ERR_MAX = 5'd16;

   // Saturating increment: the count never exceeds the number of vectors.
   function automatic logic [ERR_W-1:0] satInc(input logic [ERR_W-1:0] v);
      logic [ERR_W-1:0] r;
      if (v >= ERR_MAX) begin
         r = ERR_MAX;
      end else begin
         r = v + 5'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cell_tt_checker_if.sv
// Control, status and cell-stimulus bundle between a test controller and the checker.
// The slave side is the checker; the master side drives start/config and the cell output.
interface cell_tt_checker_if;
   import cell_test_pkg::*;

   logic                 start;
   logic                 stop_on_fail;
   logic [15:0]          expect_tt;
   logic                 dut_y;
   logic [VEC_W-1:0]     drv;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [ERR_W-1:0]     err_count;
   logic [VEC_W-1:0]     first_fail_vec;
   logic                 first_fail_valid;

   modport master (
      output start, stop_on_fail, expect_tt, dut_y,
      input  drv, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, stop_on_fail, expect_tt, dut_y,
      output drv, busy, done, pass, err_count, first_fail_vec, first_fail_valid
   );

endinterface

// File: rtl/cell_tt_checker_sync2.sv
// Two-flop synchronizer with synchronous active-low reset.
// Generic single-bit building block for bringing asynchronous levels into clk.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic stable_r;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r   <= 1'b0;
         stable_r <= 1'b0;
      end else begin
         meta_r   <= d;
         stable_r <= meta_r;
      end
   end

   assign q = stable_r;

endmodule

// File: rtl/cell_tt_checker.sv
// Sweeps all 16 input vectors of a 4-input cell, holds each for SETTLE cycles and
// compares the synchronized cell output with an expected truth table.
module cell_tt_checker
   import cell_test_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   cell_tt_checker_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   state_t              state_r, stateNext_s;
   logic [VEC_W-1:0]    vec_r, vecNext_s;
   logic [CNT_W-1:0]    cnt_r, cntNext_s;
   logic [15:0]         expectTt_r, expectTtNext_s;
   logic                stopOnFail_r, stopOnFailNext_s;
   logic [ERR_W-1:0]    errCount_r, errCountNext_s;
   logic [VEC_W-1:0]    ffVec_r, ffVecNext_s;
   logic                ffValid_r, ffValidNext_s;
   logic                busy_r, busyNext_s;
   logic                done_r, doneNext_s;
   logic                pass_r, passNext_s;
   logic                syncY_s;
   logic                mismatch_s;

   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.dut_y),
      .q     (syncY_s)
   );

   assign mismatch_s = (syncY_s != expectTt_r[vec_r]);

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         vec_r        <= 4'd0;
         cnt_r        <= 4'd0;
         expectTt_r   <= 16'd0;
         stopOnFail_r <= 1'b0;
         errCount_r   <= 5'd0;
         ffVec_r      <= 4'd0;
         ffValid_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
      end else begin
         state_r      <= stateNext_s;
         vec_r        <= vecNext_s;
         cnt_r        <= cntNext_s;
         expectTt_r   <= expectTtNext_s;
         stopOnFail_r <= stopOnFailNext_s;
         errCount_r   <= errCountNext_s;
         ffVec_r      <= ffVecNext_s;
         ffValid_r    <= ffValidNext_s;
         busy_r       <= busyNext_s;
         done_r       <= doneNext_s;
         pass_r       <= passNext_s;
      end
   end

   // Next-state, sweep counters, compare bookkeeping and next status flags.
   always_comb begin
      stateNext_s      = state_r;
      vecNext_s        = vec_r;
      cntNext_s        = cnt_r;
      expectTtNext_s   = expectTt_r;
      stopOnFailNext_s = stopOnFail_r;
      errCountNext_s   = errCount_r;
      ffVecNext_s      = ffVec_r;
      ffValidNext_s    = ffValid_r;

      case (state_r)
         IDLE, DONE: begin
            if (bus.start) begin
               expectTtNext_s   = bus.expect_tt;
               stopOnFailNext_s = bus.stop_on_fail;
               vecNext_s        = 4'd0;
               cntNext_s        = 4'd0;
               errCountNext_s   = 5'd0;
               ffVecNext_s      = 4'd0;
               ffValidNext_s    = 1'b0;
               stateNext_s      = RUN;
            end else begin
               stateNext_s      = state_r;
            end
         end
         RUN: begin
            if (cnt_r == LAST_CNT) begin
               if (mismatch_s) begin
                  errCountNext_s = satInc(errCount_r);
                  if (!ffValid_r) begin
                     ffVecNext_s   = vec_r;
                     ffValidNext_s = 1'b1;
                  end else begin
                     ffVecNext_s   = ffVec_r;
                  end
               end else begin
                  errCountNext_s = errCount_r;
               end
               // Abort freezes vec so drv keeps showing the failing vector.
               if (mismatch_s && stopOnFail_r) begin
                  stateNext_s = DONE;
               end else if (vec_r == LAST_VEC) begin
                  stateNext_s = DONE;
               end else begin
                  vecNext_s = vec_r + 4'd1;
                  cntNext_s = 4'd0;
               end
            end else begin
               cntNext_s = cnt_r + 4'd1;
            end
         end
         default: begin
            stateNext_s = IDLE;
         end
      endcase

      busyNext_s = (stateNext_s == RUN);
      doneNext_s = (stateNext_s == DONE);
      passNext_s = doneNext_s && (errCountNext_s == 5'd0);
   end

   assign bus.drv              = vec_r;
   assign bus.busy             = busy_r;
   assign bus.done             = done_r;
   assign bus.pass             = pass_r;
   assign bus.err_count        = errCount_r;
   assign bus.first_fail_vec   = ffVec_r;
   assign bus.first_fail_valid = ffValid_r;

endmodule

// File: tb/tb_cell_tt_checker.sv
// Directed bench for cell_tt_checker with behavioural AOI22/OAI22/stuck-at cell models.
module tb_cell_tt_checker;
   import cell_test_pkg::*;

   logic clk;
   logic rst_n;
   logic [1:0] modelSel;
   int passCnt;
   int totalCnt;

   cell_tt_checker_if ifc ();

   cell_tt_checker #(.SETTLE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: AOI22, 1: stuck-0, 2: stuck-1, 3: OAI22; v = {A1,A2,B1,B2}
   function automatic logic cellModel(input logic [1:0] sel, input logic [3:0] v);
      logic y;
      case (sel)
         2'd0:    y = ~((v[3] & v[2]) | (v[1] & v[0]));
         2'd1:    y = 1'b0;
         2'd2:    y = 1'b1;
         2'd3:    y = ~((v[3] | v[2]) & (v[1] | v[0]));
         default: y = 1'b0;
      endcase
      return y;
   endfunction

   assign ifc.dut_y = cellModel(modelSel, ifc.drv);

   task automatic startRun(input logic [15:0] tt, input logic sof);
      @(negedge clk);
      ifc.start        = 1'b1;
      ifc.expect_tt    = tt;
      ifc.stop_on_fail = sof;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
   endtask

   task automatic waitDone(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (ifc.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      ifc.start = 1'b1;
      ifc.expect_tt = 16'h0777;
      repeat (3) @(posedge clk);
      #1;
      totalCnt++; if (ifc.drv !== 4'h0) $display("FAIL reset_drv got %0h want 0", ifc.drv); else passCnt++;
      totalCnt++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", ifc.busy); else passCnt++;
      totalCnt++; if (ifc.done !== 1'b0) $display("FAIL reset_done got %0b want 0", ifc.done); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b0) $display("FAIL reset_pass got %0b want 0", ifc.pass); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd0) $display("FAIL reset_err got %0d want 0", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_valid !== 1'b0) $display("FAIL reset_ffvalid got %0b want 0", ifc.first_fail_valid); else passCnt++;
      @(negedge clk);
      ifc.start = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      totalCnt++; if (ifc.busy !== 1'b0) $display("FAIL idle_after_reset_busy got %0b want 0", ifc.busy); else passCnt++;
   endtask

   task automatic test_aoi_pass();
      int n;
      modelSel = 2'd0;
      startRun(16'h0777, 1'b0);
      totalCnt++; if (ifc.busy !== 1'b1) $display("FAIL aoi_busy got %0b want 1", ifc.busy); else passCnt++;
      waitDone(n);
      totalCnt++; if (n !== 64) $display("FAIL aoi_latency got %0d want 64", n); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b1) $display("FAIL aoi_pass got %0b want 1", ifc.pass); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd0) $display("FAIL aoi_err got %0d want 0", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_valid !== 1'b0) $display("FAIL aoi_ffvalid got %0b want 0", ifc.first_fail_valid); else passCnt++;
      totalCnt++; if (ifc.busy !== 1'b0) $display("FAIL aoi_busy_done got %0b want 0", ifc.busy); else passCnt++;
      totalCnt++; if (ifc.drv !== 4'hF) $display("FAIL aoi_drv_hold got %0h want f", ifc.drv); else passCnt++;
      repeat (3) @(posedge clk);
      #1;
      totalCnt++; if (ifc.done !== 1'b1) $display("FAIL aoi_done_hold got %0b want 1", ifc.done); else passCnt++;
   endtask

   task automatic test_stuck0();
      int n;
      modelSel = 2'd1;
      startRun(16'h0777, 1'b0);
      waitDone(n);
      totalCnt++; if (n !== 64) $display("FAIL s0_latency got %0d want 64", n); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd9) $display("FAIL s0_err got %0d want 9", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_vec !== 4'h0) $display("FAIL s0_ffvec got %0h want 0", ifc.first_fail_vec); else passCnt++;
      totalCnt++; if (ifc.first_fail_valid !== 1'b1) $display("FAIL s0_ffvalid got %0b want 1", ifc.first_fail_valid); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b0) $display("FAIL s0_pass got %0b want 0", ifc.pass); else passCnt++;
   endtask

   task automatic test_back_to_back();
      int n;
      modelSel = 2'd0;
      startRun(16'h0777, 1'b0);
      totalCnt++; if (ifc.err_count !== 5'd0) $display("FAIL b2b_err_clear got %0d want 0", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_valid !== 1'b0) $display("FAIL b2b_ffvalid_clear got %0b want 0", ifc.first_fail_valid); else passCnt++;
      totalCnt++; if (ifc.first_fail_vec !== 4'h0) $display("FAIL b2b_ffvec_clear got %0h want 0", ifc.first_fail_vec); else passCnt++;
      totalCnt++; if (ifc.done !== 1'b0) $display("FAIL b2b_done_clear got %0b want 0", ifc.done); else passCnt++;
      totalCnt++; if (ifc.drv !== 4'h0) $display("FAIL b2b_drv_zero got %0h want 0", ifc.drv); else passCnt++;
      waitDone(n);
      totalCnt++; if (n !== 64) $display("FAIL b2b_latency got %0d want 64", n); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b1) $display("FAIL b2b_pass got %0b want 1", ifc.pass); else passCnt++;
   endtask

   task automatic test_oai();
      int n;
      modelSel = 2'd3;
      startRun(16'h0777, 1'b0);
      waitDone(n);
      totalCnt++; if (n !== 64) $display("FAIL oai_latency got %0d want 64", n); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd6) $display("FAIL oai_err got %0d want 6", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_vec !== 4'h3) $display("FAIL oai_ffvec got %0h want 3", ifc.first_fail_vec); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b0) $display("FAIL oai_pass got %0b want 0", ifc.pass); else passCnt++;
   endtask

   task automatic test_stuck1_abort();
      int n;
      modelSel = 2'd2;
      startRun(16'h0777, 1'b1);
      waitDone(n);
      totalCnt++; if (n !== 16) $display("FAIL s1_abort_latency got %0d want 16", n); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd1) $display("FAIL s1_err got %0d want 1", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_vec !== 4'h3) $display("FAIL s1_ffvec got %0h want 3", ifc.first_fail_vec); else passCnt++;
      totalCnt++; if (ifc.drv !== 4'h3) $display("FAIL s1_drv_frozen got %0h want 3", ifc.drv); else passCnt++;
      repeat (5) @(posedge clk);
      #1;
      totalCnt++; if (ifc.drv !== 4'h3) $display("FAIL s1_drv_hold got %0h want 3", ifc.drv); else passCnt++;
   endtask

   task automatic test_control();
      int n;
      logic reached;
      logic sawDone;
      modelSel = 2'd1;
      startRun(16'h0777, 1'b0);
      repeat (10) @(posedge clk);
      // A restart with all-ones/abort would end the run at vec 0 if accepted.
      @(negedge clk);
      ifc.start        = 1'b1;
      ifc.expect_tt    = 16'hFFFF;
      ifc.stop_on_fail = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      totalCnt++; if (ifc.busy !== 1'b1) $display("FAIL ctl_ignore_busy got %0b want 1", ifc.busy); else passCnt++;
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ifc.drv == 4'h7) begin
            reached = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      totalCnt++; if (reached !== 1'b1) $display("FAIL ctl_reach_vec7 got %0b want 1", reached); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd6) $display("FAIL ctl_err_at_vec7 got %0d want 6", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.busy !== 1'b1) $display("FAIL ctl_busy_at_vec7 got %0b want 1", ifc.busy); else passCnt++;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      totalCnt++; if (ifc.drv !== 4'h0) $display("FAIL ctl_rst_drv got %0h want 0", ifc.drv); else passCnt++;
      totalCnt++; if (ifc.busy !== 1'b0) $display("FAIL ctl_rst_busy got %0b want 0", ifc.busy); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd0) $display("FAIL ctl_rst_err got %0d want 0", ifc.err_count); else passCnt++;
      totalCnt++; if (ifc.first_fail_valid !== 1'b0) $display("FAIL ctl_rst_ffvalid got %0b want 0", ifc.first_fail_valid); else passCnt++;
      @(negedge clk);
      rst_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (ifc.done) sawDone = 1'b1;
      end
      totalCnt++; if (sawDone !== 1'b0) $display("FAIL ctl_no_done_pulse got %0b want 0", sawDone); else passCnt++;
      modelSel = 2'd0;
      startRun(16'h0777, 1'b0);
      waitDone(n);
      totalCnt++; if (n !== 64) $display("FAIL ctl_clean_latency got %0d want 64", n); else passCnt++;
      totalCnt++; if (ifc.pass !== 1'b1) $display("FAIL ctl_clean_pass got %0b want 1", ifc.pass); else passCnt++;
      totalCnt++; if (ifc.err_count !== 5'd0) $display("FAIL ctl_clean_err got %0d want 0", ifc.err_count); else passCnt++;
   endtask

   initial begin
      passCnt          = 0;
      totalCnt         = 0;
      modelSel         = 2'd0;
      rst_n            = 1'b0;
      ifc.start        = 1'b0;
      ifc.stop_on_fail = 1'b0;
      ifc.expect_tt    = 16'h0000;
      test_reset();
      test_aoi_pass();
      test_stuck0();
      test_back_to_back();
      test_oai();
      test_stuck1_abort();
      test_control();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
